// File: rtl/vesp1_boot_loader.sv
// Program loader for vesp1_risc: zeroes program memory, then writes a header-framed byte stream
// into word memory while holding the CPU in reset until the load completes.
module vesp1_boot_loader #(
   parameter int unsigned WORD_SIZE    = 16,
   parameter int unsigned ADDRESS_SIZE = 12,
   parameter int unsigned MEM_DEPTH    = 256,
   parameter int unsigned CLEAR_WORDS  = 256
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_in_valid,
   input  logic [7:0]              i_in_data,
   output logic                    o_in_ready,
   output logic                    o_mem_we,
   output logic [ADDRESS_SIZE-1:0] o_mem_addr,
   output logic [WORD_SIZE-1:0]    o_mem_wdata,
   output logic                    o_cpu_rst,
   output logic                    o_done,
   output logic                    o_error
);

   typedef enum logic [3:0] {
      StClear,
      StHdrAHi,
      StHdrALo,
      StHdrNHi,
      StHdrNLo,
      StCheck,
      StDataHi,
      StDataLo,
      StWrite,
      StRun,
      StErr
   } state_t;

   // Bound check is done wide enough that start + count can never wrap.
   localparam int unsigned SUM_W = ADDRESS_SIZE + 5;
   localparam logic [SUM_W-1:0] MEM_LIMIT = SUM_W'(MEM_DEPTH);
   localparam logic [ADDRESS_SIZE-1:0] LAST_CLR = ADDRESS_SIZE'(CLEAR_WORDS - 1);
   localparam state_t RESET_STATE = (CLEAR_WORDS == 0) ? StHdrAHi : StClear;

   state_t                  r_state;
   logic [ADDRESS_SIZE-1:0] r_addr;
   logic [15:0]             r_rem;
   logic [7:0]              r_byte;

   logic                    w_accept;
   logic [SUM_W-1:0]        w_end_sum;

   assign w_accept  = i_in_valid & o_in_ready;
   assign w_end_sum = SUM_W'(r_addr) + SUM_W'(r_rem);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state     <= RESET_STATE;
         r_addr      <= '0;
         r_rem       <= '0;
         r_byte      <= '0;
         o_in_ready  <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_cpu_rst   <= 1'b0;
         o_done      <= 1'b0;
         o_error     <= 1'b0;
      end else begin
         o_mem_we <= 1'b0;
         unique case (r_state)
            StClear: begin
               o_mem_we    <= 1'b1;
               o_mem_addr  <= r_addr;
               o_mem_wdata <= '0;
               if (r_addr == LAST_CLR) begin
                  r_addr  <= '0;
                  r_state <= StHdrAHi;
               end else begin
                  r_addr <= r_addr + 1'b1;
               end
            end
            StHdrAHi: begin
               // Ready is raised on the first cycle here, so nothing is taken before it shows.
               o_in_ready <= 1'b1;
               if (w_accept) begin
                  r_byte  <= i_in_data;
                  r_state <= StHdrALo;
               end
            end
            StHdrALo: begin
               if (w_accept) begin
                  r_addr  <= ADDRESS_SIZE'({r_byte, i_in_data});
                  r_state <= StHdrNHi;
               end
            end
            StHdrNHi: begin
               if (w_accept) begin
                  r_byte  <= i_in_data;
                  r_state <= StHdrNLo;
               end
            end
            StHdrNLo: begin
               if (w_accept) begin
                  r_rem      <= {r_byte, i_in_data};
                  o_in_ready <= 1'b0;
                  r_state    <= StCheck;
               end
            end
            StCheck: begin
               if (r_rem == 16'd0) begin
                  o_cpu_rst <= 1'b1;
                  o_done    <= 1'b1;
                  r_state   <= StRun;
               end else if (w_end_sum > MEM_LIMIT) begin
                  o_error <= 1'b1;
                  r_state <= StErr;
               end else begin
                  o_in_ready <= 1'b1;
                  r_state    <= StDataHi;
               end
            end
            StDataHi: begin
               if (w_accept) begin
                  r_byte  <= i_in_data;
                  r_state <= StDataLo;
               end
            end
            StDataLo: begin
               if (w_accept) begin
                  o_in_ready  <= 1'b0;
                  o_mem_we    <= 1'b1;
                  o_mem_addr  <= r_addr;
                  o_mem_wdata <= WORD_SIZE'({r_byte, i_in_data});
                  r_state     <= StWrite;
               end
            end
            StWrite: begin
               r_addr <= r_addr + 1'b1;
               r_rem  <= r_rem - 1'b1;
               if (r_rem == 16'd1) begin
                  o_cpu_rst <= 1'b1;
                  o_done    <= 1'b1;
                  r_state   <= StRun;
               end else begin
                  o_in_ready <= 1'b1;
                  r_state    <= StDataHi;
               end
            end
            StRun: begin
               o_in_ready <= 1'b0;
            end
            StErr: begin
               o_in_ready <= 1'b0;
            end
            default: begin
               o_in_ready <= 1'b0;
               o_error    <= 1'b1;
               r_state    <= StErr;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vesp1_boot_loader.sv
// Scoreboard bench for vesp1_boot_loader: a stream-level model queues the expected memory writes,
// a monitor pops and compares them whenever mem_we is seen.
module tb_vesp1_boot_loader;

   localparam int unsigned WORD_SIZE    = 16;
   localparam int unsigned ADDRESS_SIZE = 12;
   localparam int unsigned MEM_DEPTH    = 256;
   localparam int unsigned CLEAR_WORDS  = 256;

   localparam int OUT_WRITES = 0;
   localparam int OUT_ZERO   = 1;
   localparam int OUT_ERR    = 2;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    in_valid = 1'b0;
   logic [7:0]              in_data = 8'h00;
   logic                    in_ready;
   logic                    mem_we;
   logic [ADDRESS_SIZE-1:0] mem_addr;
   logic [WORD_SIZE-1:0]    mem_wdata;
   logic                    cpu_rst;
   logic                    done;
   logic                    error;

   typedef struct packed {
      logic [ADDRESS_SIZE-1:0] addr;
      logic [WORD_SIZE-1:0]    data;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;

   always #5 clk = ~clk;

   vesp1_boot_loader #(
      .WORD_SIZE    (WORD_SIZE),
      .ADDRESS_SIZE (ADDRESS_SIZE),
      .MEM_DEPTH    (MEM_DEPTH),
      .CLEAR_WORDS  (CLEAR_WORDS)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (in_valid),
      .i_in_data   (in_data),
      .o_in_ready  (in_ready),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .o_cpu_rst   (cpu_rst),
      .o_done      (done),
      .o_error     (error)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every write must be announced by the model; cpu held and done low while writing.
   always @(negedge clk) begin
      if (mem_we !== 1'b0) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                     mem_addr, mem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("mem_write", {cpu_rst, done, error, mem_addr, mem_wdata},
                {3'b000, e.addr, e.data});
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_drain(input string name, input int budget);
      int t;
      t = 0;
      do begin
         @(posedge clk);
         #1;
         t++;
      end while (exp_q.size() != 0 && t < budget);
      chk({name, "_drain_left"}, exp_q.size(), 0);
   endtask

   task automatic do_reset();
      chk("stale_expected", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {in_ready, mem_we, cpu_rst, done, error, mem_addr, mem_wdata}, 0);
      for (int i = 0; i < int'(CLEAR_WORDS); i++)
         exp_q.push_back('{addr: ADDRESS_SIZE'(i), data: '0});
      rst = 1'b1;
      wait_drain("clear", CLEAR_WORDS + 50);
      chk("after_clear", {cpu_rst, done, error}, 0);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stall);
      int guard;
      guard = 0;
      forever begin
         @(negedge clk);
         if (stall && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
         end else begin
            in_valid = 1'b1;
            in_data  = b;
            if (in_ready) break;
         end
         guard++;
         if (guard > 2000) begin
            chk("handshake_timeout", in_ready, 1);
            break;
         end
      end
   endtask

   // Leaves the bench just after the edge that took the last byte.
   task automatic send_bytes(input logic [7:0] b[$], input int count, input bit stall);
      for (int i = 0; i < count; i++) send_byte(b[i], stall);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Reference model: queue the writes a stream should cause, up to max_words of them.
   task automatic expect_stream(input logic [7:0] b[$], input int max_words, output int outcome);
      int start;
      int n;
      start = int'({b[0], b[1]}) % (1 << ADDRESS_SIZE);
      n     = int'({b[2], b[3]});
      if (n == 0) begin
         outcome = OUT_ZERO;
      end else if (start + n > int'(MEM_DEPTH)) begin
         outcome = OUT_ERR;
      end else begin
         outcome = OUT_WRITES;
         for (int i = 0; i < n && i < max_words; i++)
            exp_q.push_back('{addr: ADDRESS_SIZE'(start + i), data: {b[4+2*i], b[5+2*i]}});
      end
   endtask

   task automatic run_case(input string name, input logic [7:0] b[$], input bit stall);
      int outcome;
      expect_stream(b, 1 << 16, outcome);
      send_bytes(b, b.size(), stall);
      if (outcome == OUT_WRITES) begin
         wait_drain(name, 100 + 20 * b.size());
         chk({name, "_done_cpu"}, {done, cpu_rst, error}, 3'b110);
      end else begin
         chk({name, "_hdr_check_cycle"}, {done, cpu_rst, error}, 3'b000);
         @(posedge clk);
         #1;
         if (outcome == OUT_ZERO)
            chk({name, "_zero_done"}, {done, cpu_rst, error, in_ready}, 4'b1100);
         else
            chk({name, "_err"}, {done, cpu_rst, error, in_ready}, 4'b0010);
      end
      repeat (10) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk({name, "_ignore_input"}, {in_ready, done, error},
          {1'b0, outcome != OUT_ERR, outcome == OUT_ERR});
   endtask

   initial begin
      logic [7:0] spec_s[$];
      logic [7:0] b[$];
      int         outcome;

      spec_s = '{8'h00, 8'h03, 8'h00, 8'h06, 8'h20, 8'h00, 8'h00, 8'h08,
                 8'h20, 8'h01, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h70, 8'h00};

      do_reset();
      run_case("spec_stream", spec_s, 1'b0);

      do_reset();
      run_case("spec_stall", spec_s, 1'b1);

      do_reset();
      b = '{8'h00, 8'hFA, 8'h00, 8'h0A};
      run_case("over_bound", b, 1'b0);

      do_reset();
      b = '{8'h00, 8'h10, 8'h00, 8'h00};
      run_case("zero_count", b, 1'b0);

      // Fills exactly to the top word; upper nibble of the address is ignored.
      do_reset();
      b = '{8'hA0, 8'hFC, 8'h00, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78,
            8'h9A, 8'hBC, 8'hDE, 8'hF0};
      run_case("top_fit", b, 1'b1);

      do_reset();
      b = '{8'h00, 8'hFD, 8'h00, 8'h04};
      run_case("one_over", b, 1'b0);

      do_reset();
      b = '{8'h0F, 8'hFF, 8'hFF, 8'hFF};
      run_case("wide_sum", b, 1'b0);

      do_reset();
      expect_stream(spec_s, 3, outcome);
      send_bytes(spec_s, 10, 1'b0);
      wait_drain("abort", 100);
      chk("abort_not_done", {done, cpu_rst, error}, 0);
      do_reset();
      run_case("after_abort", spec_s, 1'b1);

      for (int k = 0; k < 6; k++) begin
         int n;
         int st;
         int kind;
         kind = $urandom_range(0, 2);
         n    = $urandom_range(1, 6);
         if (kind == 0) begin
            st = $urandom_range(0, MEM_DEPTH - n);
         end else if (kind == 1) begin
            st = $urandom_range(MEM_DEPTH - n + 1, MEM_DEPTH - 1);
         end else begin
            st = $urandom_range(0, MEM_DEPTH - 1);
            n  = 0;
         end
         b = {};
         b.push_back({4'($urandom_range(0, 15)), 4'(st >> 8)});
         b.push_back(8'(st));
         b.push_back(8'(n >> 8));
         b.push_back(8'(n));
         if (kind != 1) begin
            for (int i = 0; i < 2 * n; i++) b.push_back(8'($urandom));
         end
         do_reset();
         run_case("random", b, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
